spi_controller: RTL and testbench



---
 rtl/spi_controller.sv | 160 ++++++++++++++++
 tb/tb_spi_controller.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_controller.sv
`default_nettype none
// ============================================================================
// Module   : spi_controller
// Brief    : SPI mode-0 initiator with a valid/ready byte interface; bytes
//            handed over with tx_last=0 stay under one cs assertion.
// Revision : 1.0 - initial release
// ============================================================================
module spi_controller #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       sclk,
    output logic       cs,
    output logic       pico,
    input  logic       poci
);

    localparam logic [7:0] c_div_m1   = 8'(CLK_DIV - 1);
    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_setup = 3'd1;
    localparam logic [2:0] c_st_shift = 3'd2;
    localparam logic [2:0] c_st_hold  = 3'd3;
    localparam logic [2:0] c_st_gap   = 3'd4;
    localparam logic [2:0] c_st_wait  = 3'd5;

    logic [2:0] r_state;
    logic [7:0] r_cnt;
    logic [3:0] r_half;
    logic [7:0] r_tx_shift;
    logic [7:0] r_rx_shift;
    logic [7:0] r_rx_data;
    logic       r_last;
    logic       r_sclk;
    logic       r_cs;
    logic       r_pico;
    logic       r_tx_ready;
    logic       r_busy;
    logic       r_rx_valid;

    logic w_accept;
    logic w_cnt_done;

    assign w_accept   = tx_valid && r_tx_ready;
    assign w_cnt_done = (r_cnt == 8'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_cnt      <= 8'd0;
            r_half     <= 4'd0;
            r_tx_shift <= 8'd0;
            r_rx_shift <= 8'd0;
            r_rx_data  <= 8'd0;
            r_last     <= 1'b0;
            r_sclk     <= 1'b0;
            r_cs       <= 1'b1;
            r_pico     <= 1'b0;
            r_tx_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                c_st_idle, c_st_wait: begin
                    if (w_accept) begin
                        r_state    <= c_st_setup;
                        r_cnt      <= c_div_m1;
                        r_cs       <= 1'b0;
                        r_pico     <= tx_data[7];
                        r_tx_shift <= {tx_data[6:0], 1'b0};
                        r_last     <= tx_last;
                        r_tx_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                c_st_setup: begin
                    if (w_cnt_done) begin
                        r_state    <= c_st_shift;
                        r_cnt      <= c_div_m1;
                        r_half     <= 4'd0;
                        r_sclk     <= 1'b1;
                        r_rx_shift <= {r_rx_shift[6:0], poci};
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                c_st_shift: begin
                    if (w_cnt_done) begin
                        r_cnt <= c_div_m1;
                        if (r_sclk) begin
                            r_sclk <= 1'b0;
                            // Half 14 ends with the 8th falling edge: byte complete
                            if (r_half == 4'd14) begin
                                r_rx_data  <= r_rx_shift;
                                r_rx_valid <= 1'b1;
                                r_state    <= r_last ? c_st_hold : c_st_wait;
                                r_tx_ready <= !r_last;
                            end else begin
                                r_pico     <= r_tx_shift[7];
                                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                                r_half     <= r_half + 4'd1;
                            end
                        end else begin
                            r_sclk     <= 1'b1;
                            r_rx_shift <= {r_rx_shift[6:0], poci};
                            r_half     <= r_half + 4'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                c_st_hold: begin
                    if (w_cnt_done) begin
                        r_state <= c_st_gap;
                        r_cnt   <= c_div_m1;
                        r_cs    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                c_st_gap: begin
                    if (w_cnt_done) begin
                        r_state    <= c_st_idle;
                        r_pico     <= 1'b0;
                        r_tx_ready <= 1'b1;
                        r_busy     <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: begin
                    r_state    <= c_st_idle;
                    r_sclk     <= 1'b0;
                    r_cs       <= 1'b1;
                    r_pico     <= 1'b0;
                    r_tx_ready <= 1'b1;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign tx_ready = r_tx_ready;
    assign rx_valid = r_rx_valid;
    assign rx_data  = r_rx_data;
    assign busy     = r_busy;
    assign sclk     = r_sclk;
    assign cs       = r_cs;
    assign pico     = r_pico;

endmodule
`default_nettype wire

// File: tb/tb_spi_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_controller
// Brief    : Self-checking bench for spi_controller at CLK_DIV=4 and 1, with a
//            bit-stream target model and timeline expectations from formulas.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid [2];
    logic [7:0] tx_data  [2];
    logic       tx_last  [2];
    logic       tx_ready [2];
    logic       rx_valid [2];
    logic [7:0] rx_data  [2];
    logic       busy     [2];
    logic       sclk     [2];
    logic       cs       [2];
    logic       pico     [2];
    logic       poci     [2];

    int total = 0;
    int bad   = 0;

    logic        lb       = 1'b1;
    logic [63:0] tgt_bits = 64'd0;
    int          tgt_n    = 0;

    int   cs_rises   [2] = '{0, 0};
    int   sclk_rises [2] = '{0, 0};
    int   rxv_cnt    [2] = '{0, 0};
    logic cs_q       [2] = '{1'b1, 1'b1};
    logic sclk_q     [2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;

    spi_controller #(.CLK_DIV(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]), .tx_data(tx_data[0]), .tx_last(tx_last[0]),
        .rx_valid(rx_valid[0]), .rx_data(rx_data[0]), .busy(busy[0]),
        .sclk(sclk[0]), .cs(cs[0]), .pico(pico[0]), .poci(poci[0])
    );

    spi_controller #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]), .tx_data(tx_data[1]), .tx_last(tx_last[1]),
        .rx_valid(rx_valid[1]), .rx_data(rx_data[1]), .busy(busy[1]),
        .sclk(sclk[1]), .cs(cs[1]), .pico(pico[1]), .poci(poci[1])
    );

    // Target replies with a continuous bit stream, restarting whenever cs rises
    always @(posedge sclk[0] or posedge cs[0]) begin
        if (cs[0]) tgt_n <= 0;
        else       tgt_n <= tgt_n + 1;
    end

    assign poci[0] = lb ? pico[0] : tgt_bits[63 - (tgt_n % 64)];
    assign poci[1] = pico[1];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (cs[d] === 1'b1 && cs_q[d] === 1'b0) cs_rises[d]++;
            if (sclk[d] === 1'b1 && sclk_q[d] === 1'b0) sclk_rises[d]++;
            if (rx_valid[d] === 1'b1) rxv_cnt[d]++;
            cs_q[d]   = cs[d];
            sclk_q[d] = sclk[d];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One byte; observation index k counts cycles after the accept edge (k=1 first)
    task automatic xfer(input int d, input logic [7:0] b, input logic last,
                        input logic [7:0] exp_rx, input bit ign);
        int c, stop, n, rises, rxv_rel, rxv_len, cs_hi_rel, rdy_rel;
        int bad_cs, bad_rdy, bad_busy, bad_sclk;
        logic [7:0] pico_seen, rxd;
        logic prev, exp_sclk;
        c = (d == 0) ? 4 : 1;
        stop = last ? 1 + 18 * c : 1 + 16 * c;
        rises = 0; rxv_rel = 0; rxv_len = 0; cs_hi_rel = 0; rdy_rel = 0;
        bad_cs = 0; bad_rdy = 0; bad_busy = 0; bad_sclk = 0;
        pico_seen = 8'd0; rxd = 8'd0; prev = 1'b0;
        @(negedge clk);
        n = 0;
        while (tx_ready[d] !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(n < 300), 32'd1);
        tx_valid[d] = 1'b1; tx_data[d] = b; tx_last[d] = last;
        @(posedge clk);
        for (int k = 1; k <= stop; k++) begin
            @(negedge clk);
            if (ign && tx_ready[d] !== 1'b1) begin
                tx_valid[d] = 1'b1;
                tx_data[d]  = 8'($urandom);
                tx_last[d]  = 1'($urandom);
            end else begin
                tx_valid[d] = 1'b0;
            end
            exp_sclk = (k >= 1 + c && k < 1 + 17 * c) && (((k - 1 - c) / c) % 2 == 0);
            if (sclk[d] !== exp_sclk) bad_sclk++;
            if (sclk[d] === 1'b1 && prev === 1'b0) begin
                if (rises < 8) pico_seen[7 - rises] = pico[d];
                rises++;
            end
            prev = sclk[d];
            if (rx_valid[d] === 1'b1) begin
                rxv_len++;
                if (rxv_rel == 0) begin rxv_rel = k; rxd = rx_data[d]; end
            end
            if (cs[d] === 1'b1 && cs_hi_rel == 0) cs_hi_rel = k;
            if (k < 1 + 17 * c && cs[d] !== 1'b0) bad_cs++;
            if (tx_ready[d] === 1'b1 && rdy_rel == 0) rdy_rel = k;
            if (k < stop && tx_ready[d] !== 1'b0) bad_rdy++;
            if ((k < stop || !last) && busy[d] !== 1'b1) bad_busy++;
        end
        tx_valid[d] = 1'b0;
        check("sclk_shape_errs", bad_sclk, 0);
        check("rise_count", rises, 8);
        check("pico_at_rises", pico_seen, b);
        check("rx_valid_cycle", rxv_rel, 1 + 16 * c);
        check("rx_valid_width", rxv_len, 1);
        check("rx_data", rxd, exp_rx);
        check("cs_high_cycle", cs_hi_rel, last ? 1 + 17 * c : 0);
        check("cs_low_errs", bad_cs, 0);
        check("tx_ready_cycle", rdy_rel, stop);
        check("tx_ready_busy_errs", bad_rdy, 0);
        check("busy_errs", bad_busy, 0);
    endtask

    initial begin
        int n, r, nb, v;
        logic [7:0] rb;
        for (int d = 0; d < 2; d++) begin
            tx_valid[d] = 1'b0; tx_data[d] = 8'd0; tx_last[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_cs", cs[d], 1);
            check("rst_sclk", sclk[d], 0);
            check("rst_pico", pico[d], 0);
            check("rst_tx_ready", tx_ready[d], 1);
            check("rst_busy", busy[d], 0);
            check("rst_rx_valid", rx_valid[d], 0);
            check("rst_rx_data", rx_data[d], 0);
        end
        rst = 1'b0;

        // Loopback single byte at both dividers
        lb = 1'b1;
        xfer(0, 8'hA5, 1'b1, 8'hA5, 1'b0);
        xfer(1, 8'h96, 1'b1, 8'h96, 1'b0);

        // Two-byte burst against the target model
        lb = 1'b0;
        tgt_bits = {8'h5A, 8'h0F, 48'd0};
        n = cs_rises[0]; r = sclk_rises[0];
        xfer(0, 8'h3C, 1'b0, 8'h5A, 1'b0);
        xfer(0, 8'hC3, 1'b1, 8'h0F, 1'b0);
        check("burst_cs_rises", cs_rises[0] - n, 1);
        check("burst_sclk_rises", sclk_rises[0] - r, 16);

        // Stall in WAIT, then finish with an all-ones reply
        tgt_bits = {8'h24, 8'hFF, 48'd0};
        xfer(0, 8'h66, 1'b0, 8'h24, 1'b0);
        v = 0;
        repeat (100) begin
            @(negedge clk);
            if (cs[0] !== 1'b0 || sclk[0] !== 1'b0 || tx_ready[0] !== 1'b1 || busy[0] !== 1'b1) v++;
        end
        check("wait_stall_errs", v, 0);
        xfer(0, 8'hFF, 1'b1, 8'hFF, 1'b0);

        // Reset after the third rising sclk edge
        lb = 1'b1;
        @(negedge clk);
        tx_valid[0] = 1'b1; tx_data[0] = 8'hE7; tx_last[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid[0] = 1'b0;
        n = 0; r = sclk_rises[0];
        while (sclk_rises[0] - r < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_reach_rise3", 32'(n < 200), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_cs", cs[0], 1);
        check("rst_mid_sclk", sclk[0], 0);
        check("rst_mid_pico", pico[0], 0);
        check("rst_mid_tx_ready", tx_ready[0], 1);
        check("rst_mid_busy", busy[0], 0);
        check("rst_mid_rx_data", rx_data[0], 0);
        rst = 1'b0;
        r = rxv_cnt[0];
        repeat (80) @(negedge clk);
        check("rst_mid_no_rx_valid", rxv_cnt[0] - r, 0);
        xfer(0, 8'h81, 1'b1, 8'h81, 1'b0);

        // Offers while busy must be ignored
        xfer(0, 8'h3A, 1'b1, 8'h3A, 1'b1);
        xfer(1, 8'hC5, 1'b1, 8'hC5, 1'b1);

        // Random bursts against random target replies
        lb = 1'b0;
        for (int it = 0; it < 4; it++) begin
            tgt_bits = {$urandom, $urandom};
            nb = $urandom_range(1, 3);
            for (int i = 0; i < nb; i++) begin
                rb = 8'($urandom);
                xfer(0, rb, 1'(i == nb - 1), tgt_bits[63 - 8 * i -: 8], 1'($urandom_range(0, 1)));
            end
        end
        for (int it = 0; it < 4; it++) begin
            rb = 8'($urandom);
            xfer(1, rb, 1'(it == 3 || $urandom_range(0, 1) == 1), rb, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
